// File: rtl/alu_issue_sched_pkg.sv
// alu_sched_pkg: shared types for the ALU issue scheduler.
//   ex_entry_t    - execute-stage payload (op, d1, d2, tag)
//   wb_entry_t    - writeback-buffer payload (tag, data)
//   sched_state_t - {ex_valid, wb_valid} pipeline occupancy
//   n_req_ok()    - legal requester-count range (2..8)
package alu_sched_pkg;

    localparam int SCHED_N_REQ = 4;
    localparam int SCHED_BW    = 32;
    localparam int SCHED_TAG_W = 6;
    localparam int OP_W        = 4;

    typedef struct packed {
        logic [OP_W-1:0]        op;
        logic [SCHED_BW-1:0]    d1;
        logic [SCHED_BW-1:0]    d2;
        logic [SCHED_TAG_W-1:0] tag;
    } ex_entry_t;

    typedef struct packed {
        logic [SCHED_TAG_W-1:0] tag;
        logic [SCHED_BW-1:0]    data;
    } wb_entry_t;

    // Encoding is {ex_valid, wb_valid} so the valid bits read straight off.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_EXEC  = 2'b10,
        ST_FULL  = 2'b11
    } sched_state_t;

    function automatic bit n_req_ok(input int n);
        return (n >= 2) && (n <= 8);
    endfunction

endpackage

// File: rtl/para.sv
// ALU choice-code encodings shared by the core's ALU and anything that
// drives or models it. The issue scheduler passes these codes through
// untouched; only the ALU itself decodes them.
package para;

    localparam logic [3:0] alu_add = 4'd0;
    localparam logic [3:0] alu_sub = 4'd1;
    localparam logic [3:0] alu_and = 4'd2;
    localparam logic [3:0] alu_or  = 4'd3;
    localparam logic [3:0] alu_xor = 4'd4;
    localparam logic [3:0] alu_sll = 4'd5;
    localparam logic [3:0] alu_srl = 4'd6;
    localparam logic [3:0] alu_slt = 4'd7;

endpackage

// File: rtl/alu_issue_sched_if.sv
// alu_issue_sched_if: requester, ALU and CDB signals of the issue scheduler.
//   req_valid/op/d1/d2/tag -> scheduler, req_ready <- scheduler (one-hot)
//   alu_d1/d2/choice       <- scheduler, alu_res -> scheduler
//   cdb_valid/tag/data     <- scheduler, cdb_ready -> scheduler
// Modports: master = environment (reservation stations, ALU, CDB),
//           slave  = scheduler.
interface alu_issue_sched_if #(
    parameter int N_REQ = 4,
    parameter int BW    = 32,
    parameter int TAG_W = 6
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][3:0]       req_op;
    logic [N_REQ-1:0][BW-1:0]    req_d1;
    logic [N_REQ-1:0][BW-1:0]    req_d2;
    logic [N_REQ-1:0][TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]            req_ready;

    logic [BW-1:0]               alu_d1;
    logic [BW-1:0]               alu_d2;
    logic [3:0]                  alu_choice;
    logic [BW-1:0]               alu_res;

    logic                        cdb_valid;
    logic                        cdb_ready;
    logic [TAG_W-1:0]            cdb_tag;
    logic [BW-1:0]               cdb_data;

    modport master (
        output req_valid, req_op, req_d1, req_d2, req_tag, alu_res, cdb_ready,
        input  req_ready, alu_d1, alu_d2, alu_choice, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  req_valid, req_op, req_d1, req_d2, req_tag, alu_res, cdb_ready,
        output req_ready, alu_d1, alu_d2, alu_choice, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/alu_issue_sched_arb.sv
// alu_rr_arbiter: one-hot grant over N requesters.
//   clock, rst_n - clock / async active-low reset (pointer only)
//   req_i        - request vector (already qualified by the caller)
//   advance_i    - a grant was taken this cycle; move the pointer
//   gnt_o        - one-hot grant, zero when req_i is zero
// Macro ALU_SCHED_RR_EN: round-robin from a pointer that moves past the last
// winner. Undefined: fixed priority, lowest index wins, no state.
module alu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);
`ifdef ALU_SCHED_RR_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx_c;
    logic          found_c;

    always_comb begin
        gnt_o   = '0;
        ptr_d   = ptr_q;
        idx_c   = '0;
        found_c = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_c = PW'((int'(ptr_q) + k) % N);
            if (!found_c && req_i[idx_c]) begin
                gnt_o[idx_c] = 1'b1;
                ptr_d        = PW'((int'(idx_c) + 1) % N);
                found_c      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (advance_i)
            ptr_q <= ptr_d;
    end
`else
    logic unused_arb;
    assign unused_arb = clock ^ rst_n ^ advance_i;

    // Two's-complement trick isolates the lowest set request bit.
    assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
`endif
endmodule

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: shares one ALU among N_REQ reservation-station requesters.
// Grants one ready requester per cycle into EX (drives the ALU), captures the
// ALU result into a single-entry WB buffer and broadcasts it on the CDB.
//   clock - rising-edge clock        rst_n - async active-low reset
//   flush - mispredict flush; kills EX and WB, blocks grants this cycle
//   bus   - alu_issue_sched_if.slave (requesters, ALU, CDB)
// Macro ALU_SCHED_RR_EN selects round-robin arbitration (default fixed
// priority, lowest index first).
//
// state    | meaning
// ---------+------------------------------------------
// ST_IDLE  | EX empty, WB empty
// ST_EXEC  | EX holds an instruction, WB empty
// ST_DRAIN | EX empty, WB holds a result for the CDB
// ST_FULL  | EX and WB both occupied
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = SCHED_N_REQ,
    parameter int BW    = SCHED_BW,
    parameter int TAG_W = SCHED_TAG_W
) (
    input  logic clock,
    input  logic rst_n,
    input  logic flush,
    alu_issue_sched_if.slave bus
);
    if (!n_req_ok(N_REQ)) begin : g_bad_n_req
        $error("alu_issue_sched: N_REQ must be within 2..8");
    end
    if (BW != SCHED_BW || TAG_W != SCHED_TAG_W) begin : g_bad_width
        $error("alu_issue_sched: BW/TAG_W must match alu_sched_pkg");
    end

    sched_state_t     state_q, state_d;
    ex_entry_t        ex_q, ex_d, sel_c;
    wb_entry_t        wb_q, wb_d;
    logic             ex_valid, wb_valid;
    logic             wb_adv, ex_free, issue_en, any_gnt;
    logic [N_REQ-1:0] arb_req, gnt;

    assign ex_valid = state_q[1];
    assign wb_valid = state_q[0];
    assign wb_adv   = ex_valid & (~wb_valid | bus.cdb_ready);
    assign ex_free  = ~ex_valid | wb_adv;
    assign issue_en = ex_free & ~flush;
    assign arb_req  = bus.req_valid & {N_REQ{issue_en}};
    assign any_gnt  = |gnt;

    alu_rr_arbiter #(.N(N_REQ)) u_arb (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_i     (arb_req),
        .advance_i (any_gnt),
        .gnt_o     (gnt)
    );

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_c.op  = bus.req_op[i];
                sel_c.d1  = bus.req_d1[i];
                sel_c.d2  = bus.req_d2[i];
                sel_c.tag = bus.req_tag[i];
            end
        end
    end

    always_comb begin
        ex_d = any_gnt ? sel_c : ex_q;
        wb_d = wb_q;
        if (wb_adv && !flush) begin
            wb_d.tag  = ex_q.tag;
            wb_d.data = bus.alu_res;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            wb_q <= wb_d;
        end
    end

    // Flush outranks everything; a refill of WB outranks a CDB acceptance.
    always_comb begin
        logic ex_nxt, wb_nxt;
        ex_nxt = ex_valid;
        wb_nxt = wb_valid;
        if (flush) begin
            ex_nxt = 1'b0;
            wb_nxt = 1'b0;
        end else begin
            if (any_gnt)
                ex_nxt = 1'b1;
            else if (wb_adv)
                ex_nxt = 1'b0;
            if (wb_adv)
                wb_nxt = 1'b1;
            else if (bus.cdb_ready)
                wb_nxt = 1'b0;
        end
        state_d = sched_state_t'({ex_nxt, wb_nxt});
    end

    always_comb begin
        bus.req_ready  = gnt;
        bus.alu_d1     = ex_q.d1;
        bus.alu_d2     = ex_q.d2;
        bus.alu_choice = ex_q.op;
        bus.cdb_valid  = wb_valid;
        bus.cdb_tag    = wb_q.tag;
        bus.cdb_data   = wb_q.data;
    end
endmodule

// File: tb/tb_alu_issue_sched.sv
module tb_alu_issue_sched;
    import para::*;

    localparam int N  = 4;
    localparam int BW = 32;
    localparam int TW = 6;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    alu_issue_sched_if #(.N_REQ(N), .BW(BW), .TAG_W(TW)) bus ();

    alu_issue_sched #(.N_REQ(N), .BW(BW), .TAG_W(TW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always_comb begin
        case (bus.alu_choice)
            alu_add: bus.alu_res = bus.alu_d1 + bus.alu_d2;
            alu_sub: bus.alu_res = bus.alu_d1 - bus.alu_d2;
            alu_and: bus.alu_res = bus.alu_d1 & bus.alu_d2;
            alu_or:  bus.alu_res = bus.alu_d1 | bus.alu_d2;
            alu_xor: bus.alu_res = bus.alu_d1 ^ bus.alu_d2;
            default: bus.alu_res = '0;
        endcase
    end

    typedef struct {
        logic [N-1:0]  rv;
        logic [3:0]    op;
        logic [31:0]   d1;
        logic [31:0]   d2;
        logic [5:0]    tag;
        logic          crdy;
        logic          fl;
        logic [N-1:0]  e_rdy;
        logic          e_cv;
        logic [5:0]    e_tag;
        logic [31:0]   e_data;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    int errors = 0;
    int checks = 0;

    int exp_idx [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] rv, input logic [3:0] op,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [5:0] tag, input logic crdy, input logic fl,
                                input logic [N-1:0] e_rdy, input logic e_cv,
                                input logic [5:0] e_tag, input logic [31:0] e_data);
        vec_t v;
        v.rv = rv; v.op = op; v.d1 = d1; v.d2 = d2; v.tag = tag;
        v.crdy = crdy; v.fl = fl;
        v.e_rdy = e_rdy; v.e_cv = e_cv; v.e_tag = e_tag; v.e_data = e_data;
        return v;
    endfunction

    // Requesters not marked valid carry junk so a wrong operand mux shows up.
    task automatic drive(input logic [N-1:0] rv, input logic [3:0] op,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [5:0] tag);
        bus.req_valid = rv;
        for (int i = 0; i < N; i++) begin
            if (rv[i]) begin
                bus.req_op[i]  = op;
                bus.req_d1[i]  = d1;
                bus.req_d2[i]  = d2;
                bus.req_tag[i] = tag;
            end else begin
                bus.req_op[i]  = alu_xor;
                bus.req_d1[i]  = 32'hDEAD_0000 | 32'(i);
                bus.req_d2[i]  = 32'h0000_BEEF;
                bus.req_tag[i] = 6'(60 + i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(4'b0001, alu_add, 32'd5,   32'd7,   6'd3,  1'b1, 1'b0, 4'b0001, 1'b0, 6'd0,  32'd0);
        tbl[1]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);
        tbl[2]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd3,  32'd12);
        tbl[3]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);
        tbl[4]  = mk(4'b0010, alu_sub, 32'd10,  32'd3,   6'd5,  1'b1, 1'b0, 4'b0010, 1'b0, 6'd0,  32'd0);
        tbl[5]  = mk(4'b0010, alu_sub, 32'd4,   32'd9,   6'd6,  1'b1, 1'b0, 4'b0010, 1'b0, 6'd0,  32'd0);
        tbl[6]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd5,  32'd7);
        tbl[7]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd6,  32'hFFFF_FFFB);
        tbl[8]  = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);
        tbl[9]  = mk(4'b0100, alu_add, 32'd1,   32'd2,   6'd10, 1'b0, 1'b0, 4'b0100, 1'b0, 6'd0,  32'd0);
        tbl[10] = mk(4'b0100, alu_add, 32'd3,   32'd4,   6'd11, 1'b0, 1'b0, 4'b0100, 1'b0, 6'd0,  32'd0);
        tbl[11] = mk(4'b0100, alu_add, 32'd5,   32'd6,   6'd12, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd10, 32'd3);
        tbl[12] = mk(4'b0100, alu_add, 32'd5,   32'd6,   6'd12, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd10, 32'd3);
        tbl[13] = mk(4'b0100, alu_add, 32'd5,   32'd6,   6'd12, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd10, 32'd3);
        tbl[14] = mk(4'b0100, alu_add, 32'd5,   32'd6,   6'd12, 1'b1, 1'b0, 4'b0100, 1'b1, 6'd10, 32'd3);
        tbl[15] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd11, 32'd7);
        tbl[16] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd12, 32'd11);
        tbl[17] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);
        tbl[18] = mk(4'b1000, alu_xor, 32'hF0,  32'hFF,  6'd20, 1'b0, 1'b0, 4'b1000, 1'b0, 6'd0,  32'd0);
        tbl[19] = mk(4'b1000, alu_or,  32'd1,   32'd2,   6'd21, 1'b0, 1'b0, 4'b1000, 1'b0, 6'd0,  32'd0);
        tbl[20] = mk(4'b1000, alu_add, 32'd9,   32'd9,   6'd22, 1'b1, 1'b1, 4'b0000, 1'b1, 6'd20, 32'h0F);
        tbl[21] = mk(4'b1000, alu_add, 32'd9,   32'd9,   6'd22, 1'b1, 1'b0, 4'b1000, 1'b0, 6'd0,  32'd0);
        tbl[22] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);
        tbl[23] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b1, 6'd22, 32'd18);
        tbl[24] = mk(4'b0000, alu_add, 32'd0,   32'd0,   6'd0,  1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'd0);

`ifdef ALU_SCHED_RR_EN
        exp_idx = '{0, 1, 2, 3, 0};
`else
        exp_idx = '{0, 0, 0, 0, 0};
`endif

        drive(4'b0000, alu_add, 32'd0, 32'd0, 6'd0);
        bus.cdb_ready = 1'b1;
        flush = 1'b0;

        // Reset values.
        #12;
        chk("reset cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("reset cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("reset cdb_data", 64'(bus.cdb_data), 64'd0);
        chk("reset alu_d1", 64'(bus.alu_d1), 64'd0);
        chk("reset alu_choice", 64'(bus.alu_choice), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);

        tick();
        rst_n = 1'b1;

        // Directed vector table: single issue, back-to-back, back-pressure, flush.
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].rv, tbl[k].op, tbl[k].d1, tbl[k].d2, tbl[k].tag);
            bus.cdb_ready = tbl[k].crdy;
            flush = tbl[k].fl;
            #2;
            chk($sformatf("row%0d req_ready", k), 64'(bus.req_ready), 64'(tbl[k].e_rdy));
            chk($sformatf("row%0d cdb_valid", k), 64'(bus.cdb_valid), 64'(tbl[k].e_cv));
            if (tbl[k].e_cv) begin
                chk($sformatf("row%0d cdb_tag", k), 64'(bus.cdb_tag), 64'(tbl[k].e_tag));
                chk($sformatf("row%0d cdb_data", k), 64'(bus.cdb_data), 64'(tbl[k].e_data));
            end
            tick();
        end
        flush = 1'b0;

        // All requesters valid: arbitration order and the matching CDB results.
        bus.cdb_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                bus.req_valid = 4'b1111;
                for (int i = 0; i < N; i++) begin
                    bus.req_op[i]  = alu_add;
                    bus.req_d1[i]  = 32'(i * 10);
                    bus.req_d2[i]  = 32'd1;
                    bus.req_tag[i] = 6'(40 + i);
                end
            end else begin
                bus.req_valid = 4'b0000;
            end
            #2;
            if (c < 5)
                chk($sformatf("arb c%0d req_ready", c), 64'(bus.req_ready), 64'(4'b0001 << exp_idx[c]));
            else
                chk($sformatf("arb c%0d req_ready", c), 64'(bus.req_ready), 64'd0);
            if (c >= 2 && c < 7) begin
                chk($sformatf("arb c%0d cdb_valid", c), 64'(bus.cdb_valid), 64'd1);
                chk($sformatf("arb c%0d cdb_tag", c), 64'(bus.cdb_tag), 64'(40 + exp_idx[c-2]));
                chk($sformatf("arb c%0d cdb_data", c), 64'(bus.cdb_data), 64'(exp_idx[c-2] * 10 + 1));
            end else begin
                chk($sformatf("arb c%0d cdb_valid", c), 64'(bus.cdb_valid), 64'd0);
            end
            tick();
        end

        // Reset mid-stream with both stages occupied.
        bus.cdb_ready = 1'b0;
        drive(4'b0001, alu_add, 32'd1, 32'd1, 6'd7);
        tick();
        drive(4'b0001, alu_add, 32'd2, 32'd3, 6'd8);
        tick();
        drive(4'b0000, alu_add, 32'd0, 32'd0, 6'd0);
        #2;
        chk("pre-reset cdb_valid", 64'(bus.cdb_valid), 64'd1);
        chk("pre-reset cdb_data", 64'(bus.cdb_data), 64'd2);
        chk("pre-reset alu_d1", 64'(bus.alu_d1), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("midrst cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("midrst cdb_data", 64'(bus.cdb_data), 64'd0);
        chk("midrst alu_d1", 64'(bus.alu_d1), 64'd0);
        chk("midrst alu_d2", 64'(bus.alu_d2), 64'd0);
        chk("midrst alu_choice", 64'(bus.alu_choice), 64'd0);
        chk("midrst req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.cdb_ready = 1'b1;
        tick();
        tick();
        chk("post-reset cdb_valid", 64'(bus.cdb_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
